// File: rtl/inertial_integrator.sv
`default_nettype none
// ============================================================================
// Module   : inertial_integrator
// Purpose  : Gyro offset calibration followed by a complementary filter that
//            integrates offset-compensated pitch rate and nudges the result
//            toward the accelerometer-derived pitch by a fixed step.
// Revision : 1.0 - initial release
// ============================================================================
module inertial_integrator #(
    parameter bit                 fast_sim  = 1'b1,
    parameter int                 CAL_LOG2  = 6,
    parameter logic signed [15:0] AZ_OFFSET = 16'sh00A0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_in,
    input  logic signed [15:0] ptch_rt_in,
    input  logic signed [15:0] AZ,
    output logic signed [15:0] ptch,
    output logic signed [15:0] ptch_rt,
    output logic               vld,
    output logic               cal_done
);

    localparam int                 c_ACC_W     = 16 + CAL_LOG2;
    localparam logic signed [27:0] c_FUSE_STEP = fast_sim ? 28'sd16384 : 28'sd1024;
    localparam logic signed [27:0] c_INT_MAX   = 28'sd67108863;
    localparam logic signed [27:0] c_INT_MIN   = -28'sd67108864;
    localparam logic signed [9:0]  c_AZ_GAIN   = 10'sd327;

    typedef enum logic [0:0] {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t                      state_q;
    logic signed [c_ACC_W-1:0]   cal_acc_q;
    logic        [CAL_LOG2-1:0]  cal_cnt_q;
    logic signed [15:0]          offset_q;
    logic signed [26:0]          ptch_int_q;
    logic signed [15:0]          ptch_rt_q;
    logic                        vld_q;
    logic                        cal_done_q;

    logic signed [c_ACC_W-1:0]   w_cal_sum;
    logic signed [15:0]          w_rt_c;
    logic signed [15:0]          w_az_c;
    logic signed [25:0]          w_prod;
    logic signed [15:0]          w_ptch_acc;
    logic signed [27:0]          w_fuse;
    logic signed [27:0]          w_int_sum;
    logic signed [26:0]          ptch_int_d;

    // Calibration running sum including the sample currently presented
    assign w_cal_sum  = cal_acc_q + c_ACC_W'(ptch_rt_in);

    // Offset-compensated rate and accelerometer-derived pitch estimate
    assign w_rt_c     = ptch_rt_in - offset_q;
    assign w_az_c     = AZ - AZ_OFFSET;
    assign w_prod     = w_az_c * c_AZ_GAIN;
    assign w_ptch_acc = 16'(w_prod >>> 13);

    // Fusion step compares against the pre-update pitch
    always_comb begin
        w_fuse = 28'sd0;
        if (w_ptch_acc > ptch) begin
            w_fuse = c_FUSE_STEP;
        end else if (w_ptch_acc < ptch) begin
            w_fuse = -c_FUSE_STEP;
        end
    end

    // Integrate in 28 bits so that overshoot is detectable, then clamp to 27
    assign w_int_sum = 28'(ptch_int_q) - 28'(w_rt_c) + w_fuse;

    // Saturating next value of the pitch integrator
    always_comb begin
        ptch_int_d = w_int_sum[26:0];
        if (w_int_sum > c_INT_MAX) begin
            ptch_int_d = c_INT_MAX[26:0];
        end else if (w_int_sum < c_INT_MIN) begin
            ptch_int_d = c_INT_MIN[26:0];
        end
    end

    // Calibration / run sequencing and all registered state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CAL;
            cal_acc_q  <= '0;
            cal_cnt_q  <= '0;
            offset_q   <= '0;
            ptch_int_q <= '0;
            ptch_rt_q  <= '0;
            vld_q      <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (vld_in) begin
                case (state_q)
                    ST_CAL: begin
                        if (cal_cnt_q == {CAL_LOG2{1'b1}}) begin
                            // Arithmetic shift gives floor division of the sum
                            offset_q   <= 16'(w_cal_sum >>> CAL_LOG2);
                            state_q    <= ST_RUN;
                            cal_done_q <= 1'b1;
                        end else begin
                            cal_acc_q <= w_cal_sum;
                            cal_cnt_q <= cal_cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        ptch_rt_q  <= w_rt_c;
                        ptch_int_q <= ptch_int_d;
                        vld_q      <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_CAL;
                    end
                endcase
            end
        end
    end

    assign ptch     = ptch_int_q[26:11];
    assign ptch_rt  = ptch_rt_q;
    assign vld      = vld_q;
    assign cal_done = cal_done_q;

endmodule
`default_nettype wire

// File: tb/tb_inertial_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_inertial_integrator
// Purpose  : Directed self-checking bench for inertial_integrator, with a
//            slow-fusion and a fast-fusion instance sharing the same inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inertial_integrator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vld_in = 1'b0;
    logic signed [15:0] ptch_rt_in = '0;
    logic signed [15:0] az = 16'sh00A0;

    logic signed [15:0] ptch_s, ptch_rt_s, ptch_f, ptch_rt_f;
    logic               vld_s, cal_done_s, vld_f, cal_done_f;

    int n_cmp = 0;
    int n_err = 0;
    int vld_cnt = 0;

    always #5 clk = ~clk;

    inertial_integrator #(.fast_sim(1'b0), .CAL_LOG2(6), .AZ_OFFSET(16'sh00A0)) dut_s (
        .clk(clk), .rst(rst), .vld_in(vld_in), .ptch_rt_in(ptch_rt_in), .AZ(az),
        .ptch(ptch_s), .ptch_rt(ptch_rt_s), .vld(vld_s), .cal_done(cal_done_s)
    );

    inertial_integrator #(.fast_sim(1'b1), .CAL_LOG2(6), .AZ_OFFSET(16'sh00A0)) dut_f (
        .clk(clk), .rst(rst), .vld_in(vld_in), .ptch_rt_in(ptch_rt_in), .AZ(az),
        .ptch(ptch_f), .ptch_rt(ptch_rt_f), .vld(vld_f), .cal_done(cal_done_f)
    );

    // Count output strobes of the slow instance, sampled just after each edge
    always @(posedge clk) begin
        #1;
        if (vld_s === 1'b1) vld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n back-to-back strobes; returns at the negedge after the last capture
    task automatic pulses(input int n, input logic [15:0] rt, input logic [15:0] a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vld_in     = 1'b1;
            ptch_rt_in = rt;
            az         = a;
        end
        @(negedge clk);
        vld_in = 1'b0;
    endtask

    // Assert reset between edges and check that outputs clear without a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_ptch"},     {16'h0, ptch_s},     32'h0);
        chk({tag, "_ptch_rt"},  {16'h0, ptch_rt_s},  32'h0);
        chk({tag, "_vld"},      {31'h0, vld_s},      32'h0);
        chk({tag, "_cal_done"}, {31'h0, cal_done_s}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          cnt0;
        logic [15:0] rt;
        logic [15:0] hold_p, hold_r;
        logic        ok;
        int          gap;

        // ---- power-on reset and calibration at 0x0040
        do_reset("rst0");
        cnt0 = vld_cnt;
        pulses(63, 16'h0040, 16'h00A0);
        chk("cal63_done", {31'h0, cal_done_s}, 32'h0);
        pulses(1, 16'h0040, 16'h00A0);
        chk("cal64_done", {31'h0, cal_done_s}, 32'h1);
        chk("cal64_vld",  {31'h0, vld_s},      32'h0);
        chk("cal_no_vld", 32'(vld_cnt - cnt0), 32'h0);

        // ---- first run sample: zero compensated rate
        pulses(1, 16'h0040, 16'h00A0);
        chk("run0_vld",     {31'h0, vld_s},     32'h1);
        chk("run0_ptch_rt", {16'h0, ptch_rt_s}, 32'h0000);
        chk("run0_ptch",    {16'h0, ptch_s},    32'h0000);
        @(negedge clk);
        chk("run0_vld_drop", {31'h0, vld_s}, 32'h0);

        // ---- gyro integration
        pulses(1, 16'h0840, 16'h00A0);
        chk("gyro1_ptch_rt", {16'h0, ptch_rt_s}, 32'h0800);
        chk("gyro1_ptch_s",  {16'h0, ptch_s},    32'hFFFF);
        chk("gyro1_ptch_f",  {16'h0, ptch_f},    32'hFFFF);
        pulses(1, 16'h0840, 16'h00A0);
        chk("gyro2_ptch_s",  {16'h0, ptch_s},    32'hFFFE);
        chk("gyro2_ptch_f",  {16'h0, ptch_f},    32'h0006);
        @(negedge clk);

        // ---- gapped strobes: one vld per vld_in, outputs hold in the gaps
        cnt0 = vld_cnt;
        for (int k = 0; k < 12; k++) begin
            rt = 16'($urandom_range(0, 65535));
            pulses(1, rt, 16'h00A0);
            chk("gap_ptch_rt", {16'h0, ptch_rt_s}, {16'h0, 16'(rt - 16'h0040)});
            hold_p = ptch_s;
            hold_r = ptch_rt_s;
            gap    = int'($urandom_range(1, 20));
            ok     = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (vld_s !== 1'b0 || ptch_s !== hold_p || ptch_rt_s !== hold_r) ok = 1'b0;
            end
            chk("gap_hold", {31'h0, ok}, 32'h1);
        end
        chk("gap_vld_count", 32'(vld_cnt - cnt0), 32'd12);

        // ---- reset in RUN, then reset mid-calibration, recalibrate at 0x0010
        do_reset("rst_run");
        pulses(30, 16'h1234, 16'h00A0);
        do_reset("rst_cal");
        pulses(63, 16'h0010, 16'h00A0);
        chk("recal63_done", {31'h0, cal_done_s}, 32'h0);
        pulses(1, 16'h0010, 16'h00A0);
        chk("recal64_done", {31'h0, cal_done_s}, 32'h1);
        pulses(1, 16'h0020, 16'h00A0);
        chk("recal_ptch_rt", {16'h0, ptch_rt_s}, 32'h0010);

        // ---- offset rounds toward minus infinity: sum -1 over 64 -> -1
        do_reset("rst_floor");
        pulses(63, 16'h0000, 16'h00A0);
        pulses(1, 16'hFFFF, 16'h00A0);
        pulses(1, 16'h0000, 16'h00A0);
        chk("floor_ptch_rt", {16'h0, ptch_rt_s}, 32'h0001);
        chk("floor_ptch",    {16'h0, ptch_s},    32'hFFFF);

        // ---- accelerometer convergence toward 163 with zero offset
        do_reset("rst_acc");
        pulses(64, 16'h0000, 16'h00A0);
        pulses(20, 16'h0000, 16'h10A0);
        chk("acc20_ptch_f", {16'h0, ptch_f}, 32'd160);
        pulses(1, 16'h0000, 16'h10A0);
        chk("acc21_ptch_f", {16'h0, ptch_f}, 32'd168);
        chk("acc21_ptch_s", {16'h0, ptch_s}, 32'd10);
        pulses(304, 16'h0000, 16'h10A0);
        chk("acc325_ptch_s", {16'h0, ptch_s}, 32'd162);
        pulses(1, 16'h0000, 16'h10A0);
        chk("acc326_ptch_s", {16'h0, ptch_s}, 32'd163);
        pulses(5, 16'h0000, 16'h10A0);
        chk("acc331_ptch_s", {16'h0, ptch_s}, 32'd163);

        // ---- saturation with maximum negative raw rate, zero offset
        do_reset("rst_sat");
        pulses(64, 16'h0000, 16'h00A0);
        pulses(1000, 16'h8000, 16'h00A0);
        chk("sat1000_ptch_s",  {16'h0, ptch_s},    32'h3C8C);
        chk("sat1000_ptch_f",  {16'h0, ptch_f},    32'h1F48);
        chk("sat1000_ptch_rt", {16'h0, ptch_rt_s}, 32'h8000);
        pulses(1200, 16'h8000, 16'h00A0);
        chk("sat2200_ptch_s",  {16'h0, ptch_s},    32'h7FFF);
        chk("sat2200_ptch_f",  {16'h0, ptch_f},    32'h44C8);
        pulses(100, 16'h8000, 16'h00A0);
        chk("sat2300_ptch_s",  {16'h0, ptch_s},    32'h7FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
